// File: rtl/kmac_ss_digest_seq.sv
// ---------------------------------------------------------------------------
// kmac_ss_digest_seq
//
// Streams the Keccak state out as 32-bit digest words for hardware consumers
// (for example the lifecycle token-hash path) instead of the software read
// window. A word index steps through the 1600-bit state. All shares are
// XOR-unmasked, an optional byte swap is applied, and each word is presented
// on a valid/ready handshake. While a sequence runs, the software state-read
// window is blocked so that both paths never observe the state concurrently.
//
// Ports
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   start_i        : request a readout; honoured only while idle
//   len_i          : number of words to stream, legal 1..NumWords
//   state_valid_i  : Keccak state holds a completed digest
//   state_i        : state shares (unpacked array, one entry per share)
//   endian_swap_i  : byte-reverse each output word
//   clear_i        : synchronous abort/flush, highest priority
//   word_o         : unmasked digest word
//   word_valid_o   : word_o valid
//   word_ready_i   : consumer accepts word_o
//   last_o         : current word is the final one (qualified by valid)
//   busy_o         : sequence in progress
//   sw_rd_block_o  : blocks the software state-read window (equals busy_o)
//   done_o         : one-cycle pulse after the final handshake
//   err_o          : one-cycle pulse on rejected start or loss of state
// ---------------------------------------------------------------------------
module kmac_ss_digest_seq #(
    parameter int unsigned StateW    = 1600,
    parameter bit          EnMasking = 1'b0,
    localparam int unsigned Share    = EnMasking ? 32'd2 : 32'd1,
    localparam int unsigned NumWords = StateW / 32'd32,
    localparam int unsigned LenW     = $clog2(NumWords + 32'd1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LenW-1:0]   len_i,
    input  logic              state_valid_i,
    input  logic [StateW-1:0] state_i [Share],
    input  logic              endian_swap_i,
    input  logic              clear_i,
    output logic [31:0]       word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              sw_rd_block_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StOut   = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e            state_q;
    logic [LenW-1:0]   idx_q;
    logic [LenW-1:0]   len_q;
    logic              swap_q;
    logic [31:0]       word_q;
    logic              valid_q;
    logic              last_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       sel_word_s;
    logic              len_ok_s;
    logic              idx_last_s;

    // Byte-reverse a word when enabled: result byte order {b0,b1,b2,b3}.
    function automatic logic [31:0] byte_swap(input logic [31:0] w, input logic en);
        logic [31:0] r;
        if (en) begin
            r = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end else begin
            r = w;
        end
        return r;
    endfunction

    // Unmask the word selected by idx_q: XOR of the same 32-bit slice of every
    // share. The compare-per-word form keeps every part-select in range, so an
    // index can never address bits beyond the state.
    always_comb begin
        sel_word_s = 32'h0000_0000;
        for (int unsigned s = 0; s < Share; s++) begin
            for (int unsigned w = 0; w < NumWords; w++) begin
                sel_word_s = sel_word_s ^
                    ((idx_q == LenW'(w)) ? state_i[s][32*w +: 32] : 32'h0000_0000);
            end
        end
    end

    // Start legality and end-of-sequence decode.
    always_comb begin
        len_ok_s   = (len_i != {LenW{1'b0}}) && (len_i <= LenW'(NumWords));
        idx_last_s = (idx_q == (len_q - {{(LenW-1){1'b0}}, 1'b1}));
    end

    // Sequencer FSM with registered outputs. clear_i outranks everything,
    // loss of state_valid_i outranks a handshake in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= {LenW{1'b0}};
            len_q   <= {LenW{1'b0}};
            swap_q  <= 1'b0;
            word_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (clear_i) begin
                state_q <= StIdle;
                idx_q   <= {LenW{1'b0}};
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (len_ok_s && state_valid_i) begin
                                len_q   <= len_i;
                                swap_q  <= endian_swap_i;
                                idx_q   <= {LenW{1'b0}};
                                state_q <= StFetch;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StFetch: begin
                        if (!state_valid_i) begin
                            err_q   <= 1'b1;
                            idx_q   <= {LenW{1'b0}};
                            state_q <= StIdle;
                        end else begin
                            word_q  <= byte_swap(sel_word_s, swap_q);
                            last_q  <= idx_last_s;
                            valid_q <= 1'b1;
                            state_q <= StOut;
                        end
                    end
                    StOut: begin
                        if (!state_valid_i) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            idx_q   <= {LenW{1'b0}};
                            state_q <= StIdle;
                        end else if (valid_q && word_ready_i) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (last_q) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                idx_q   <= idx_q + {{(LenW-1){1'b0}}, 1'b1};
                                state_q <= StFetch;
                            end
                        end
                    end
                    StDone: begin
                        idx_q   <= {LenW{1'b0}};
                        state_q <= StIdle;
                    end
                    default: begin
                        idx_q   <= {LenW{1'b0}};
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign word_o        = word_q;
    assign word_valid_o  = valid_q;
    assign last_o        = last_q;
    assign busy_o        = (state_q != StIdle);
    assign sw_rd_block_o = (state_q != StIdle);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_kmac_ss_digest_seq.sv
// ---------------------------------------------------------------------------
// Bench for kmac_ss_digest_seq. Two instances share all control inputs: one
// unmasked (fed the pre-combined state) and one masked (fed both shares), so
// both must produce identical streams. A transaction-level model predicts the
// outputs every cycle; directed literals pin the model to known values.
// ---------------------------------------------------------------------------
module tb_kmac_ss_digest_seq;

    localparam int StateW   = 1600;
    localparam int NumWords = 50;
    localparam int LenW     = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            start, sv, swap, clr, ready;
    logic [LenW-1:0] len;
    logic [StateW-1:0] s0, s1;
    logic [StateW-1:0] st_u [1];
    logic [StateW-1:0] st_m [2];

    always_comb begin
        st_u[0] = s0 ^ s1;
        st_m[0] = s0;
        st_m[1] = s1;
    end

    logic [31:0] word_u, word_m;
    logic valid_u, valid_m, last_u, last_m, busy_u, busy_m;
    logic blk_u, blk_m, done_u, done_m, err_u, err_m;

    kmac_ss_digest_seq #(.StateW(StateW), .EnMasking(1'b0)) dut_u (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len),
        .state_valid_i(sv), .state_i(st_u), .endian_swap_i(swap), .clear_i(clr),
        .word_o(word_u), .word_valid_o(valid_u), .word_ready_i(ready),
        .last_o(last_u), .busy_o(busy_u), .sw_rd_block_o(blk_u),
        .done_o(done_u), .err_o(err_u)
    );

    kmac_ss_digest_seq #(.StateW(StateW), .EnMasking(1'b1)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len),
        .state_valid_i(sv), .state_i(st_m), .endian_swap_i(swap), .clear_i(clr),
        .word_o(word_m), .word_valid_o(valid_m), .word_ready_i(ready),
        .last_o(last_m), .busy_o(busy_m), .sw_rd_block_o(blk_m),
        .done_o(done_m), .err_o(err_m)
    );

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int last_cnt = 0;
    int done_cnt = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected digest word k: per-byte XOR of both shares, then optional swap.
    function automatic logic [31:0] exp_word(input int k, input logic sw);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) begin
            b[i] = s0[32*k + 8*i +: 8] ^ s1[32*k + 8*i +: 8];
        end
        return sw ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    endfunction

    // Transaction model: a sequence is "running" from accepted start until the
    // final handshake; a word is "offered" on every second cycle of a run until
    // accepted; a one-cycle "tail" follows the final handshake.
    logic m_run = 1'b0, m_out = 1'b0, m_tail = 1'b0, m_swap = 1'b0;
    logic m_done = 1'b0, m_err = 1'b0;
    int   m_k = 0, m_len = 0;

    // Model update on the same edge the design samples its inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_out <= 1'b0; m_tail <= 1'b0; m_swap <= 1'b0;
            m_done <= 1'b0; m_err <= 1'b0; m_k <= 0; m_len <= 0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (clr) begin
                m_run <= 1'b0; m_out <= 1'b0; m_tail <= 1'b0;
            end else if (m_tail) begin
                m_tail <= 1'b0;
            end else if (!m_run) begin
                if (start) begin
                    if (int'(len) >= 1 && int'(len) <= NumWords && sv) begin
                        m_run <= 1'b1; m_out <= 1'b0; m_k <= 0;
                        m_len <= int'(len); m_swap <= swap;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (!sv) begin
                m_run <= 1'b0; m_out <= 1'b0; m_err <= 1'b1;
            end else if (!m_out) begin
                m_out <= 1'b1;
            end else if (ready) begin
                m_out <= 1'b0;
                if (m_k == m_len - 1) begin
                    m_run <= 1'b0; m_tail <= 1'b1; m_done <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model, mid-cycle.
    always @(negedge clk) begin
        chk1("busy_u",  busy_u,  m_run | m_tail);
        chk1("busy_m",  busy_m,  m_run | m_tail);
        chk1("block_u", blk_u,   m_run | m_tail);
        chk1("block_m", blk_m,   m_run | m_tail);
        chk1("valid_u", valid_u, m_out);
        chk1("valid_m", valid_m, m_out);
        chk1("done_u",  done_u,  m_done);
        chk1("done_m",  done_m,  m_done);
        chk1("err_u",   err_u,   m_err);
        chk1("err_m",   err_m,   m_err);
        if (m_out) begin
            chk32("word_u", word_u, exp_word(m_k, m_swap));
            chk32("word_m", word_m, exp_word(m_k, m_swap));
            chk1("last_u", last_u, (m_k == m_len - 1));
            chk1("last_m", last_m, (m_k == m_len - 1));
        end
        if (valid_u && ready) hs_cnt++;
        if (valid_u && ready && last_u) last_cnt++;
        if (done_u) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int l, input logic sw);
        len   = LenW'(l);
        swap  = sw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s: no done within %0d cycles, expected one", nm, budget);
        end
    endtask

    initial begin
        int h0, l0, d0, n;
        rst_n = 1'b0; start = 1'b0; sv = 1'b1; swap = 1'b0; clr = 1'b0;
        ready = 1'b1; len = '0; s0 = '0; s1 = '0;
        repeat (3) tick();
        chk32("reset_word", word_u, 32'h0000_0000);
        chk1("reset_last", last_u, 1'b0);
        rst_n = 1'b1;
        tick();

        // Unmasked-style data, len=2, no swap, ready high.
        s0[31:0]  = 32'h1122_3344;
        s0[63:32] = 32'hAABB_CCDD;
        pulse_start(2, 1'b0);
        tick();
        chk32("t1_w0_u", word_u, 32'h1122_3344);
        chk32("t1_w0_m", word_m, 32'h1122_3344);
        chk1("t1_last0", last_u, 1'b0);
        tick(); tick();
        chk32("t1_w1_u", word_u, 32'hAABB_CCDD);
        chk1("t1_last1", last_u, 1'b1);
        tick();
        chk1("t1_done", done_u, 1'b1);
        chk1("t1_busy_done", busy_u, 1'b1);
        tick();
        chk1("t1_idle", busy_u, 1'b0);

        // Masked shares with swap, len=1.
        s0 = '0; s1 = '0;
        s0[31:0] = 32'hFFFF_0000;
        s1[31:0] = 32'h0F0F_0F0F;
        pulse_start(1, 1'b1);
        chk1("t2_block", blk_m, 1'b1);
        tick();
        chk32("t2_word_m", word_m, 32'h0F0F_F0F0);
        chk32("t2_word_u", word_u, 32'h0F0F_F0F0);
        chk1("t2_last", last_m, 1'b1);
        wait_done("t2_done", 10);
        tick();

        // Fill every word with a distinct pattern in both shares.
        for (int w = 0; w < NumWords; w++) begin
            s0[32*w +: 32] = (32'(w) * 32'h0101_0101) ^ 32'hC300_0000;
            s1[32*w +: 32] = 32'h5A5A_0000 | 32'(w);
        end

        // Backpressure: hold ready low five cycles; stray starts are ignored.
        ready = 1'b0;
        pulse_start(3, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            chk32("t3_hold_word", word_u, exp_word(0, 1'b0));
            chk1("t3_hold_valid", valid_u, 1'b1);
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
        wait_done("t3_done", 20);
        tick();

        // Rejected starts.
        pulse_start(0, 1'b0);
        chk1("t4_len0_err", err_u, 1'b1);
        chk1("t4_len0_busy", busy_u, 1'b0);
        tick();
        pulse_start(51, 1'b0);
        chk1("t4_len51_err", err_m, 1'b1);
        chk1("t4_len51_busy", busy_m, 1'b0);
        tick();
        sv = 1'b0;
        pulse_start(4, 1'b0);
        chk1("t4_sv_err", err_u, 1'b1);
        chk1("t4_sv_busy", busy_u, 1'b0);
        sv = 1'b1;
        tick();

        // Full 50-word stream.
        h0 = hs_cnt; l0 = last_cnt; d0 = done_cnt;
        pulse_start(50, 1'b1);
        wait_done("t5_done", 200);
        tick(); tick();
        chki("t5_words", hs_cnt - h0, 50);
        chki("t5_lasts", last_cnt - l0, 1);
        chki("t5_dones", done_cnt - d0, 1);

        // Clear on word 3 of 10 (with a simultaneous handshake).
        pulse_start(10, 1'b0);
        n = 0;
        while (!(m_out && m_k == 3) && n < 100) begin
            tick();
            n++;
        end
        chk1("t6_reach_w3", valid_u, 1'b1);
        d0 = done_cnt;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk1("t6_valid", valid_u, 1'b0);
        chk1("t6_busy", busy_u, 1'b0);
        chk1("t6_err", err_u, 1'b0);
        chk1("t6_done", done_u, 1'b0);
        pulse_start(2, 1'b0);
        tick();
        chk32("t6_restart_w0", word_u, exp_word(0, 1'b0));
        wait_done("t6_done2", 10);
        tick();

        // state_valid drop during fetch.
        pulse_start(4, 1'b0);
        sv = 1'b0;
        tick();
        chk1("t7_err", err_m, 1'b1);
        chk1("t7_valid", valid_m, 1'b0);
        chk1("t7_busy", busy_m, 1'b0);
        sv = 1'b1;
        pulse_start(2, 1'b1);
        tick();
        chk32("t7_restart_w0", word_m, exp_word(0, 1'b1));
        wait_done("t7_done", 10);
        tick();

        // Clear beats start in idle: no error, no run.
        clr = 1'b1;
        pulse_start(3, 1'b0);
        clr = 1'b0;
        chk1("t8_err", err_u, 1'b0);
        chk1("t8_busy", busy_u, 1'b0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
